// File: rtl/s3g_tx_pkt.sv
// s3g_tx_pkt: ping-pong buffered S3G packet framer (D5, LEN, payload, CRC8) feeding a UART byte transmitter; optional resend via S3G_TX_RETX_EN
module s3g_tx_pkt #(
    parameter int MAX_LEN = 32,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ld_data,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic       packet_wr,
    output logic       pkt_ready,
    output logic       cmd_err,
    input  logic       resend,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic       busy
);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    typedef enum logic [1:0] {IDLE, LEN, DATA, CRC} state_t;
    state_t state, state_n;
    logic [7:0] mem [2][MAX_LEN];
    logic ld_bank, q_bank, tx_bank, queued;
    logic [CNT_W-1:0] ld_cnt, ld_len, q_len, tx_len, byte_cnt, cnt_n;
    logic [7:0] crc, crc_n, crc_upd, cur, data_n;
    logic wr_n, deq, done_pkt, wr_en, commit, re_ok, err;
    assign busy = (state != IDLE) | queued;
    assign pkt_ready = !queued;
    assign ld_ready = (ld_cnt != CNT_W'(MAX_LEN)) && !((state != IDLE) && (tx_bank == ld_bank));
    assign wr_en = ld_valid && ld_ready;
    assign commit = packet_wr && !queued;
    assign ld_len = ld_cnt + CNT_W'(wr_en);
    assign cur = mem[tx_bank][byte_cnt[AW-1:0]];
`ifdef S3G_TX_RETX_EN
    logic sent;
    assign re_ok = resend && !commit && state == IDLE && !queued && sent;
    assign err = (packet_wr && queued) || (resend && !re_ok);
    // remember that a packet has completed, so a resend has something to repeat
    always_ff @(posedge clk)
        sent <= rst ? 1'b0 : sent | done_pkt;
`else
    logic unused_resend;
    assign unused_resend = resend;
    assign re_ok = 1'b0;
    assign err = packet_wr && queued;
`endif
    // reflected Dallas/Maxim CRC-8 step over one payload byte
    always_comb begin
        crc_upd = crc ^ cur;
        for (int i = 0; i < 8; i++)
            crc_upd = crc_upd[0] ? (crc_upd >> 1) ^ 8'h8C : crc_upd >> 1;
    end
    // framing FSM: next state and next UART byte/strobe
    always_comb begin
        state_n = state;
        wr_n = 1'b0;
        data_n = tx_data;
        cnt_n = byte_cnt;
        crc_n = crc;
        deq = 1'b0;
        done_pkt = 1'b0;
        case (state)
            IDLE: if (queued) begin
                state_n = LEN;
                wr_n = 1'b1;
                data_n = 8'hD5;
                deq = 1'b1;
            end
            LEN: if (tx_done) begin
                state_n = DATA;
                wr_n = 1'b1;
                data_n = 8'(tx_len);
                cnt_n = '0;
                crc_n = '0;
            end
            DATA: if (tx_done) begin
                wr_n = 1'b1;
                if (byte_cnt != tx_len) begin
                    data_n = cur;
                    crc_n = crc_upd;
                    cnt_n = byte_cnt + CNT_W'(1);
                end else begin
                    data_n = crc;
                    state_n = CRC;
                end
            end
            CRC: if (tx_done) begin
                done_pkt = 1'b1;
                if (queued) begin
                    state_n = LEN;
                    wr_n = 1'b1;
                    data_n = 8'hD5;
                    deq = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // datapath, load bookkeeping and packet queue
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr <= 1'b0;
            tx_data <= '0;
            byte_cnt <= '0;
            crc <= '0;
            cmd_err <= 1'b0;
            ld_cnt <= '0;
            ld_bank <= 1'b0;
            q_bank <= 1'b0;
            q_len <= '0;
            queued <= 1'b0;
            tx_bank <= 1'b0;
            tx_len <= '0;
        end else begin
            tx_wr <= wr_n;
            tx_data <= data_n;
            byte_cnt <= cnt_n;
            crc <= crc_n;
            cmd_err <= err;
            ld_cnt <= commit ? '0 : ld_len;
            if (commit) begin
                ld_bank <= ~ld_bank;
                q_bank <= ld_bank;
                q_len <= ld_len;
            end else if (re_ok) begin
                q_bank <= tx_bank;
                q_len <= tx_len;
            end
            queued <= (commit || re_ok) ? 1'b1 : deq ? 1'b0 : queued;
            if (deq) begin
                tx_bank <= q_bank;
                tx_len <= q_len;
            end
        end
    end
    // payload bank write port
    always_ff @(posedge clk)
        if (wr_en) mem[ld_bank][ld_cnt[AW-1:0]] <= ld_data;
endmodule

// File: tb/tb_s3g_tx_pkt.sv
// tb_s3g_tx_pkt: randomized scoreboard bench for s3g_tx_pkt with a packet-level reference model
module tb_s3g_tx_pkt;
    localparam int MAX_LEN = 32;
    localparam int GAP = 3;
    logic clk = 0, rst = 1, ld_valid = 0, packet_wr = 0, resend = 0, tx_done = 0;
    logic [7:0] ld_data = 0;
    logic ld_ready, pkt_ready, cmd_err, tx_wr, busy;
    logic [7:0] tx_data;
    int n_chk = 0, n_pass = 0, wr_seen = 0, cyc = 0, last_wr = 0, ucnt = 0;
    logic [8:0] exp_q[$], last_q[$];
    logic [7:0] mbuf[$];

    s3g_tx_pkt #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .packet_wr(packet_wr), .pkt_ready(pkt_ready), .cmd_err(cmd_err), .resend(resend),
        .tx_done(tx_done), .tx_data(tx_data), .tx_wr(tx_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // UART model: tx_done one cycle, GAP cycles after each tx_wr
    initial forever begin
        @(negedge clk);
        tx_done = 0;
        if (rst) ucnt = 0;
        else if (ucnt != 0) begin
            ucnt--;
            if (ucnt == 0) tx_done = 1;
        end else if (tx_wr) ucnt = GAP - 1;
    end

    // monitor: every strobe pops one expected byte
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && tx_wr) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_tx_wr: got %02h, expected no strobe", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e[7:0]);
                    if (e[8]) chk("b2b_gap", cyc - last_wr, GAP);
                end
                last_wr = cyc;
                wr_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        ld_data = b;
        ld_valid = 1;
        tick();
        ld_valid = 0;
        if (mbuf.size() < MAX_LEN) mbuf.push_back(b);
    endtask

    // expected frame from the model buffer: bit-serial Maxim CRC over the payload
    task automatic build(input logic b2b);
        logic [7:0] c, b;
        logic mix;
        c = 0;
        last_q.delete();
        last_q.push_back({b2b, 8'hD5});
        last_q.push_back({1'b0, 8'(mbuf.size())});
        foreach (mbuf[k]) begin
            b = mbuf[k];
            last_q.push_back({1'b0, b});
            for (int i = 0; i < 8; i++) begin
                mix = c[0] ^ b[i];
                c = c >> 1;
                if (mix) c = c ^ 8'h8C;
            end
        end
        last_q.push_back({1'b0, c});
    endtask

    task automatic commit(input logic with_b, input logic [7:0] b, input logic err, input logic b2b);
        ld_data = b;
        ld_valid = with_b;
        packet_wr = 1;
        tick();
        packet_wr = 0;
        ld_valid = 0;
        chk("cmd_err", cmd_err, err);
        if (with_b && mbuf.size() < MAX_LEN) mbuf.push_back(b);
        if (!err) begin
            build(b2b);
            foreach (last_q[k]) exp_q.push_back(last_q[k]);
            mbuf.delete();
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 1000) begin
            tick();
            i++;
        end
        chk("idle_timeout", busy, 0);
        chk("pending_bytes", exp_q.size(), 0);
    endtask

    task automatic wait_wr(input int n);
        int i = 0;
        while (wr_seen < n && i < 400) begin
            tick();
            i++;
        end
        chk("wr_timeout", wr_seen >= n, 1);
    endtask

    initial begin
        int base, n;
        logic wb;
        repeat (3) tick();
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_pkt_ready", pkt_ready, 1);
        rst = 0;
        tick();
        // single byte 0x01 -> D5 01 01 5E
        push_byte(8'h01);
        commit(0, 0, 0, 0);
        wait_idle();
        // empty packet
        commit(0, 0, 0, 0);
        wait_idle();
        // overflow: MAX_LEN+2 bytes, last two dropped
        for (int i = 0; i < MAX_LEN + 2; i++) begin
            push_byte(8'(i));
            if (i == MAX_LEN - 2) chk("ld_ready_room", ld_ready, 1);
            if (i == MAX_LEN - 1) chk("ld_ready_full", ld_ready, 0);
        end
        commit(0, 0, 0, 0);
        wait_idle();
        // back-to-back: A sending while B loads and queues, third commit rejected
        base = wr_seen;
        push_byte(8'hAA);
        push_byte(8'hBB);
        commit(0, 0, 0, 0);
        wait_wr(base + 1);
        chk("ld_ready_other_bank", ld_ready, 1);
        push_byte(8'hCC);
        commit(0, 0, 0, 1);
        chk("ld_ready_txbank", ld_ready, 0);
        chk("pkt_ready_queued", pkt_ready, 0);
        commit(0, 0, 1, 0);
        wait_idle();
        // reset during DATA of a 5-byte packet
        base = wr_seen;
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        commit(0, 0, 0, 0);
        wait_wr(base + 4);
        rst = 1;
        exp_q.delete();
        mbuf.delete();
        tick();
        tick();
        chk("mid_rst_tx_wr", tx_wr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pkt_ready", pkt_ready, 1);
        rst = 0;
        repeat (12) tick();
        chk("post_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        commit(0, 0, 0, 0);
        wait_idle();
        // randomized packets, lengths spanning 0..MAX_LEN+2
        for (int p = 0; p < 15; p++) begin
            n = $urandom_range(0, MAX_LEN + 2);
            wb = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                push_byte(8'($urandom));
            end
            commit(wb, 8'($urandom), 0, 0);
            wait_idle();
        end
`ifdef S3G_TX_RETX_EN
        push_byte(8'h01);
        commit(0, 0, 0, 0);
        wait_idle();
        resend = 1;
        tick();
        resend = 0;
        chk("resend_ok_err", cmd_err, 0);
        foreach (last_q[k]) exp_q.push_back(last_q[k]);
        resend = 1;
        tick();
        resend = 0;
        chk("resend_busy_err", cmd_err, 1);
        wait_idle();
`else
        resend = 1;
        tick();
        resend = 0;
        chk("resend_ignored_err", cmd_err, 0);
        repeat (10) tick();
        chk("resend_ignored_busy", busy, 0);
`endif
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/s3g_tx_pkt.md
Name: s3g_tx_pkt

Overview:
- Parametrised S3G packet transmitter, successor to the fixed 16-byte parallel-buffer transmitter.
- Payload is streamed in byte-wise into a ping-pong pair of MAX_LEN-byte banks, so one packet loads while the previous one transmits.
- Each packet is framed as 0xD5, LEN, payload, CRC8 and driven one byte at a time into the UART byte transmitter (tx_wr/tx_done handshake).
- Sits between the host-response assembly logic and the UART TX.

Parameters:
- MAX_LEN, 32, maximum payload bytes per packet (1..255); each bank is MAX_LEN bytes.
- CNT_W, 8, width of the length/byte counters; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ld_data  in  8  payload byte to append to the load bank.
- ld_valid  in  1  append ld_data this cycle (accepted only when ld_ready=1).
- ld_ready  out  1  load bank writable and not full.
- packet_wr  in  1  commit the load bank as a packet; LEN = bytes appended.
- pkt_ready  out  1  a commit is accepted this cycle (no packet already queued).
- cmd_err  out  1  one-cycle pulse: packet_wr or resend was ignored.
- resend  in  1  retransmit the last sent packet (functional only with S3G_TX_RETX_EN).
- tx_done  in  1  UART finished the previous byte.
- tx_data  out  8  byte to UART, registered.
- tx_wr  out  1  one-cycle write strobe to UART, registered.
- busy  out  1  packet in flight or queued.

Behaviour:
- Reset: all state clears and any queued packet is discarded.
  - tx_data=0, tx_wr=0, busy=0, cmd_err=0, ld_ready=1, pkt_ready=1.
  - Load count=0, load bank=0, FSM=IDLE, no packet sent yet.
  - Reset mid-packet aborts the packet immediately; no further tx_wr is issued.
- Loading:
  - Banks are used in strict alternation: each accepted commit toggles the load bank.
  - ld_ready=0 when load count==MAX_LEN, or when the load bank is currently being transmitted.
  - A byte presented while ld_ready=0 is dropped; the count does not change.
  - ld_valid and packet_wr in the same cycle: the byte is included in the committed packet.
- Commit:
  - Accepted when pkt_ready=1. The bank becomes queued with LEN=count (0 allowed), and the count resets to 0.
  - packet_wr when pkt_ready=0: the commit is ignored, cmd_err pulses, and the loaded data is kept.
- FSM states: IDLE, LEN, DATA, CRC.
  - IDLE: with a packet queued, the next edge sets tx_data=0xD5, tx_wr=1, busy=1, dequeues the packet and goes to LEN.
  - LEN on tx_done: tx_data=LEN, tx_wr=1, byte_cnt=0, crc=0, go to DATA.
  - DATA on tx_done, byte_cnt!=LEN: send bank[byte_cnt], update crc with that byte, byte_cnt+1.
  - DATA on tx_done, byte_cnt==LEN: send crc, go to CRC.
  - CRC on tx_done, packet queued: emit 0xD5 the same cycle and go to LEN (back-to-back packets).
  - CRC on tx_done, nothing queued: go to IDLE, busy=0.
  - tx_done in IDLE is ignored.
  - An illegal state returns to IDLE.
- Output timing:
  - tx_wr is exactly one cycle wide, on the edge after the tx_done that triggers it.
  - tx_data holds its value between strobes.
- CRC:
  - Dallas/Maxim CRC-8 (poly x^8+x^5+x^4+1, reflected, init 0x00), covering payload bytes only.
  - The next CRC value is combinational from the current CRC and the byte.
- busy = (state!=IDLE) | queued.

Optional Feature:
- Macro S3G_TX_RETX_EN.
- Defined: a resend pulse is accepted when state=IDLE, nothing is queued, and at least one packet has completed since reset.
  - The last-sent bank is re-queued with its original LEN and transmitted identically.
  - Contents are intact because loading targets the other bank.
  - A resend outside those conditions pulses cmd_err.
- Undefined: resend is ignored entirely (no cmd_err) and the last-sent tracking logic is removed.

Test Plan:
- Load 0x01, packet_wr, tx_done 3 cycles after every tx_wr -> tx_data sequence D5,01,01,5E; busy drops on the edge after the final tx_done.
- packet_wr with 0 bytes loaded -> D5,00,00; no DATA bytes are sent.
- Append MAX_LEN+2 bytes 0x00..0x21 (MAX_LEN=32) -> ld_ready low after 32 bytes; LEN=0x20; bytes 0x20,0x21 are absent.
- Commit packet A (02 AA BB), load and commit B (01 CC) while A is sending, then issue packet_wr again -> cmd_err pulses; A's CRC is immediately followed by D5 of B without an idle gap.
- Assert rst during DATA of a 5-byte packet -> tx_wr stays 0, busy=0, pkt_ready=1; a fresh packet then transmits correctly.
- S3G_TX_RETX_EN: send 0x01, then resend while IDLE -> D5,01,01,5E repeated; resend during transmission -> cmd_err pulse and no extra packet.
